// File: rtl/ap_mult_pkg.sv
// Shared definitions for the approximate pipelined multiplier.
// Holds the column-geometry helpers of the partial-product matrix, the compressor
// constants used by the carry-save reduction, and the level clamp.
package ap_mult_pkg;

    // Each 3:2 compressor takes three rows and leaves two, and each 4:2 takes four and leaves two.
    localparam int unsigned C32_IN  = 3;
    localparam int unsigned C32_OUT = 2;
    localparam int unsigned C42_IN  = 4;
    localparam int unsigned C42_OUT = 2;

    // Number of partial-product bits that land in column c of a width x width matrix.
    function automatic int unsigned col_pp_count(int unsigned c, int unsigned width);
        if (c >= 2 * width - 1) begin
            return 0;
        end
        return (c < width) ? c + 1 : 2 * width - 1 - c;
    endfunction

    // Lowest multiplier row that contributes to column c.
    function automatic int unsigned col_row_lo(int unsigned c, int unsigned width);
        return (c < width) ? 0 : c - width + 1;
    endfunction

    // Effective approximation level, min(level, ap_max).
    function automatic int unsigned clamp_level(int unsigned level, int unsigned ap_max);
        return (level > ap_max) ? ap_max : level;
    endfunction

endpackage

// File: rtl/ap_col_reduce.sv
// Combinational column processing for the approximate multiplier.
// Columns below le are OR-reduced into or_vec and contribute no carries. The remaining bits
// are reduced to a sum row and a carry row with a chain of 4:2 compressors (built from two
// 3:2 stages), with one trailing 3:2 when the row count leaves a remainder.
// Ports:
//   pp        in   pp[i][j] = a[j] & b[i], weight column i+j
//   le        in   effective approximation level
//   sum_row   out  carry-save sum row of the unmasked bits
//   carry_row out  carry-save carry row of the unmasked bits
//   or_vec    out  per-column OR of the approximated columns (zero at and above le)
module ap_col_reduce
    import ap_mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned LVL_W  = 5,
    parameter int unsigned AP_MAX = 12
) (
    input  logic [WIDTH-1:0][WIDTH-1:0] pp,
    input  logic [LVL_W-1:0]            le,
    output logic [2*WIDTH-1:0]          sum_row,
    output logic [2*WIDTH-1:0]          carry_row,
    output logic [2*WIDTH-1:0]          or_vec
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned STEP42 = C42_IN - C42_OUT;
    localparam int unsigned REM = (WIDTH - C42_OUT) % STEP42;

    function automatic logic [PW-1:0] csa_sum(logic [PW-1:0] x, logic [PW-1:0] y,
                                              logic [PW-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PW-1:0] csa_carry(logic [PW-1:0] x, logic [PW-1:0] y,
                                                logic [PW-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [PW-1:0] rows [WIDTH];
    int unsigned   le_n;

    assign le_n = 32'(le);

    // Shifted, masked partial-product rows: bits in approximated columns are removed.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rows[i] = '0;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                rows[i][i+j] = pp[i][j] & (i + j >= le_n);
            end
        end
    end

    always_comb begin
        int unsigned lo;
        lo = 0;
        or_vec = '0;
        for (int unsigned c = 0; c < AP_MAX; c++) begin
            lo = col_row_lo(c, WIDTH);
            for (int unsigned k = 0; k < col_pp_count(c, WIDTH); k++) begin
                or_vec[c] = or_vec[c] | pp[lo+k][c-lo-k];
            end
            or_vec[c] = or_vec[c] & (c < le_n);
        end
    end

    always_comb begin
        logic [PW-1:0] s1;
        logic [PW-1:0] c1;
        s1 = '0;
        c1 = '0;
        sum_row   = rows[0];
        carry_row = rows[1];
        for (int unsigned k = C42_OUT; k + STEP42 <= WIDTH; k += STEP42) begin
            s1        = csa_sum(sum_row, carry_row, rows[k]);
            c1        = csa_carry(sum_row, carry_row, rows[k]);
            sum_row   = csa_sum(s1, c1, rows[k+1]);
            carry_row = csa_carry(s1, c1, rows[k+1]);
        end
        if (REM == C32_IN - C32_OUT) begin
            s1        = csa_sum(sum_row, carry_row, rows[WIDTH-1]);
            carry_row = csa_carry(sum_row, carry_row, rows[WIDTH-1]);
            sum_row   = s1;
        end
    end

endmodule

// File: rtl/ap_mult_pipe.sv
// Three-stage pipelined unsigned WIDTH x WIDTH multiplier with a per-beat approximation level.
// S1 registers operands and the clamped level, S2 registers the carry-save rows and the OR
// vector of the approximated columns, S3 registers the final sum. All stages advance together
// when the output is empty or being consumed, so backpressure stalls the whole pipe.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b operands, in_level requested level
//   out_valid/out_ready  result handshake; out_res product, out_level effective level
//   busy                 any stage holds a valid beat
module ap_mult_pipe
    import ap_mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned LVL_W  = 5,
    parameter int unsigned AP_MAX = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [LVL_W-1:0]   in_level,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_res,
    output logic [LVL_W-1:0]   out_level,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;

    logic adv;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [LVL_W-1:0] s1_le_q;

    logic             s2_valid_q;
    logic [PW-1:0]    s2_sum_q;
    logic [PW-1:0]    s2_carry_q;
    logic [PW-1:0]    s2_or_q;
    logic [LVL_W-1:0] s2_le_q;

    logic [WIDTH-1:0][WIDTH-1:0] pp;
    logic [PW-1:0]               sum_row;
    logic [PW-1:0]               carry_row;
    logic [PW-1:0]               or_vec;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = s1_valid_q | s2_valid_q | out_valid;

    // Valid bits: bubbles propagate as zeros, everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_a_q  <= in_a;
            s1_b_q  <= in_b;
            s1_le_q <= LVL_W'(clamp_level(32'(in_level), AP_MAX));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pp[i] = s1_a_q & {WIDTH{s1_b_q[i]}};
        end
    end

    ap_col_reduce #(
        .WIDTH  (WIDTH),
        .LVL_W  (LVL_W),
        .AP_MAX (AP_MAX)
    ) u_col_reduce (
        .pp        (pp),
        .le        (s1_le_q),
        .sum_row   (sum_row),
        .carry_row (carry_row),
        .or_vec    (or_vec)
    );

    always_ff @(posedge clk) begin
        if (adv && s1_valid_q) begin
            s2_sum_q   <= sum_row;
            s2_carry_q <= carry_row;
            s2_or_q    <= or_vec;
            s2_le_q    <= s1_le_q;
        end
    end

    // The exact part is a multiple of 2^Le, so OR-ing in the low field cannot collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_level <= '0;
        end else if (adv) begin
            out_valid <= s2_valid_q;
            if (s2_valid_q) begin
                out_res   <= (s2_sum_q + s2_carry_q) | s2_or_q;
                out_level <= s2_le_q;
            end
        end
    end

endmodule

// File: tb/tb_ap_mult_pipe.sv
module tb_ap_mult_pipe;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned LVL_W  = 5;
    localparam int unsigned AP_MAX = 12;
    localparam int unsigned PW     = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [LVL_W-1:0] in_level;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_res;
    logic [LVL_W-1:0] out_level;
    logic             busy;

    ap_mult_pipe #(
        .WIDTH  (WIDTH),
        .LVL_W  (LVL_W),
        .AP_MAX (AP_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_level  (in_level),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_level (out_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0]    res;
        logic [LVL_W-1:0] lvl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: one 4-cycle stall on first result
    int   stall_left = 0;
    bit   stall_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Column-wise golden model: OR below Le, exact weighted count at and above Le.
    function automatic logic [PW-1:0] model_res(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [LVL_W-1:0] lvl);
        int unsigned     le;
        int unsigned     cnt;
        longint unsigned acc;
        logic [PW-1:0]   orv;
        le  = 32'(lvl);
        if (le > AP_MAX) le = AP_MAX;
        acc = 0;
        orv = '0;
        for (int unsigned c = 0; c < PW - 1; c++) begin
            cnt = 0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (c >= i && c - i < WIDTH) begin
                    if (a[c-i] && b[i]) cnt++;
                end
            end
            if (c < le) orv[c] = (cnt != 0);
            else acc += longint'(cnt) << c;
        end
        return PW'(acc) | orv;
    endfunction

    function automatic logic [LVL_W-1:0] model_lvl(input logic [LVL_W-1:0] lvl);
        return (32'(lvl) > AP_MAX) ? LVL_W'(AP_MAX) : lvl;
    endfunction

    // Drive one beat starting at a negedge; returns at the negedge after it is accepted.
    task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [LVL_W-1:0] lvl, input logic [PW-1:0] eres,
                              input logic [LVL_W-1:0] elvl);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_level = lvl;
        forever begin
            #1;
            if (in_ready) begin
                sb.push_back('{res: eres, lvl: elvl});
                n_in++;
                @(negedge clk);
                break;
            end
            guard++;
            if (guard > 200) begin
                chk("accept_timeout", 32'(guard), 32'(0));
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [LVL_W-1:0] lvl);
        drive_beat(a, b, lvl, model_res(a, b, lvl), model_lvl(lvl));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    // Output-ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_done && out_valid) begin
                        stall_done = 1'b1;
                        stall_left = 3;
                        out_ready  = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every presented result with the scoreboard head; a stalled result is
    // compared every cycle it is held, and popped only on transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                chk("in_ready_vs_out_ready", 32'(in_ready), 32'(out_ready));
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(out_res), 32'(0));
                    errors += (out_res == '0) ? 1 : 0;
                end else begin
                    e = sb[0];
                    chk("out_res", 32'(out_res), 32'(e.res));
                    chk("out_level", 32'(out_level), 32'(e.lvl));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [LVL_W-1:0] lvl;
        logic [PW-1:0]    res;
        logic [LVL_W-1:0] elvl;
    } vec_t;

    vec_t vecs[11];
    int   lat;
    int   t0;

    initial begin
        vecs[0]  = '{12'd4095, 12'd4095, 5'd0,  24'd16769025, 5'd0};
        vecs[1]  = '{12'd3,    12'd3,    5'd2,  24'd7,        5'd2};
        vecs[2]  = '{12'd4095, 12'd1,    5'd31, 24'd4095,     5'd12};
        vecs[3]  = '{12'd7,    12'd7,    5'd3,  24'd39,       5'd3};
        vecs[4]  = '{12'd2,    12'd2,    5'd1,  24'd4,        5'd1};
        vecs[5]  = '{12'd5,    12'd6,    5'd0,  24'd30,       5'd0};
        vecs[6]  = '{12'd0,    12'd4095, 5'd12, 24'd0,        5'd12};
        vecs[7]  = '{12'd4095, 12'd4095, 5'd12, 24'd16728063, 5'd12};
        vecs[8]  = '{12'd4095, 12'd4095, 5'd24, 24'd16728063, 5'd12};
        vecs[9]  = '{12'd4095, 12'd4095, 5'd11, 24'd16750591, 5'd11};
        vecs[10] = '{12'd6,    12'd5,    5'd13, 24'd30,       5'd12};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_level = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_out_res", 32'(out_res), 32'(0));
        chk("reset_out_level", 32'(out_level), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);

        // Latency of a lone exact beat.
        drive_beat(vecs[0].a, vecs[0].b, vecs[0].lvl, vecs[0].res, vecs[0].elvl);
        lat = 1;
        #2;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            #2;
            lat++;
        end
        chk("latency", 32'(lat), 32'(3));
        @(negedge clk);
        drain();

        // Directed table, back to back.
        for (int i = 1; i < 11; i++) begin
            drive_beat(vecs[i].a, vecs[i].b, vecs[i].lvl, vecs[i].res, vecs[i].elvl);
        end
        drain();

        // Backpressure: five beats, four stalled cycles on the first result.
        stall_done = 1'b0;
        stall_left = 0;
        ready_mode = 2;
        for (int i = 1; i < 6; i++) begin
            drive_beat(vecs[i].a, vecs[i].b, vecs[i].lvl, vecs[i].res, vecs[i].elvl);
        end
        drain();
        chk("stall_happened", 32'(stall_done), 32'(1));
        ready_mode = 0;
        chk("count_after_stall", 32'(n_out), 32'(n_in));

        // Reset with two beats in flight.
        drive_beat(vecs[3].a, vecs[3].b, vecs[3].lvl, vecs[3].res, vecs[3].elvl);
        drive_beat(vecs[5].a, vecs[5].b, vecs[5].lvl, vecs[5].res, vecs[5].elvl);
        rst = 1'b1;
        n_in -= sb.size();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_busy", 32'(busy), 32'(0));
        chk("flush_out_res", 32'(out_res), 32'(0));
        @(negedge clk);
        repeat (6) @(negedge clk);
        chk("flush_no_result", 32'(n_out), 32'(n_in));

        // Throughput with out_ready held high.
        t0 = cyc;
        for (int i = 0; i < 50; i++) begin
            drive_model(WIDTH'($urandom), WIDTH'($urandom), LVL_W'($urandom));
        end
        chk("throughput_cycles", 32'(cyc - t0), 32'(50));
        drain();

        // Random operands, levels, gaps and backpressure.
        ready_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            drive_model(WIDTH'($urandom), WIDTH'($urandom), LVL_W'($urandom));
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        drain();
        ready_mode = 0;
        chk("final_count", 32'(n_out), 32'(n_in));
        chk("final_busy", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
